// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one 16x16 MAC walks all taps per input sample.
// Samples live in a circular buffer; coefficients in a host-writable memory.
module fir_mac_sequencer #(
  parameter int unsigned TAP_NUM = 321,
  parameter int unsigned ACC_W   = 48,
  parameter int unsigned AW      = $clog2(TAP_NUM)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [15:0]  data_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [31:0]  data_out,
  output logic                out_sat,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                coeff_we,
  input  logic [AW-1:0]       coeff_addr,
  input  logic signed [15:0]  coeff_wdata,
  output logic                busy
);

  localparam logic [AW-1:0] LastIdx = AW'(TAP_NUM - 1);

  typedef enum logic [2:0] {StClear, StIdle, StRun, StFlush, StDone} state_e;

  state_e                    state_q;
  logic [AW-1:0]             wr_ptr_q, rd_ptr_q, k_q, clr_cnt_q;
  logic signed [31:0]        prod_q;
  logic                      pvld_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [15:0]        sbuf [TAP_NUM];
  logic signed [15:0]        coeff_mem [TAP_NUM];

  logic signed [31:0]        mult;
  logic signed [ACC_W-1:0]   acc_sum;
  logic [ACC_W-32:0]         acc_hi;
  logic signed [31:0]        sat_data;
  logic                      sat_flag;
  logic                      coeff_ok;

  assign mult    = 32'(sbuf[rd_ptr_q]) * 32'(coeff_mem[k_q]);
  assign acc_sum = acc_q + ACC_W'(prod_q);
  assign acc_hi  = acc_sum[ACC_W-1:31];

  // Result fits in 32 bits only when all bits above bit 31 match the sign.
  always_comb begin
    sat_flag = 1'b0;
    sat_data = acc_sum[31:0];
    if (!(acc_hi == '0 || acc_hi == '1)) begin
      sat_flag = 1'b1;
      sat_data = acc_sum[ACC_W-1] ? 32'sh8000_0000 : 32'sh7fff_ffff;
    end
  end

  // Coefficients are never reset and are frozen while the MAC is walking them.
  assign coeff_ok = coeff_we && (coeff_addr <= LastIdx) &&
                    (state_q == StClear || state_q == StIdle || state_q == StDone);

  always_ff @(posedge clk) begin
    if (coeff_ok) coeff_mem[coeff_addr] <= coeff_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StClear;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      k_q       <= '0;
      clr_cnt_q <= '0;
      prod_q    <= '0;
      pvld_q    <= 1'b0;
      acc_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      out_sat   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          sbuf[clr_cnt_q] <= '0;
          clr_cnt_q       <= clr_cnt_q + AW'(1);
          if (clr_cnt_q == LastIdx) begin
            state_q  <= StIdle;
            in_ready <= 1'b1;
          end
        end
        StIdle: begin
          if (in_valid) begin
            sbuf[wr_ptr_q] <= data_in;
            rd_ptr_q       <= wr_ptr_q;
            k_q            <= '0;
            acc_q          <= '0;
            pvld_q         <= 1'b0;
            in_ready       <= 1'b0;
            busy           <= 1'b1;
            state_q        <= StRun;
          end
        end
        StRun: begin
          // Product is registered; accumulate it one cycle later.
          prod_q <= mult;
          pvld_q <= 1'b1;
          if (pvld_q) acc_q <= acc_sum;
          rd_ptr_q <= (rd_ptr_q == '0) ? LastIdx : rd_ptr_q - AW'(1);
          k_q      <= k_q + AW'(1);
          if (k_q == LastIdx) state_q <= StFlush;
        end
        StFlush: begin
          acc_q     <= acc_sum;
          data_out  <= sat_data;
          out_sat   <= sat_flag;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            wr_ptr_q  <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + AW'(1);
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Randomized bench for fir_mac_sequencer against a direct convolution model.
module tb_fir_mac_sequencer;

  localparam int N  = 321;
  localparam int AW = $clog2(N);

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] data_in;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] data_out;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready;
  logic               coeff_we;
  logic [AW-1:0]      coeff_addr;
  logic signed [15:0] coeff_wdata;
  logic               busy;

  fir_mac_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_out    (data_out),
    .out_sat     (out_sat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .coeff_we    (coeff_we),
    .coeff_addr  (coeff_addr),
    .coeff_wdata (coeff_wdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: coefficient table, sample history, write position.
  int mcoef [N];
  int mbuf  [N];
  int mwr;
  int prev_acc;
  logic signed [63:0] last_d;
  logic               last_s;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // y[n] = sum_k x[n-k]*c[k], clipped to signed 32 bits.
  function automatic void model_out(output logic signed [63:0] d, output logic s);
    longint sum = 0;
    for (int k = 0; k < N; k++) sum += longint'(mbuf[(mwr - k + N) % N]) * mcoef[k];
    s = 1'b1;
    if (sum > 64'sd2147483647)       d = 64'sd2147483647;
    else if (sum < -64'sd2147483648) d = -64'sd2147483648;
    else begin
      d = sum;
      s = 1'b0;
    end
  endfunction

  task automatic do_reset(input int ncyc);
    int n   = 0;
    int bad = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    coeff_we = 1'b0;
    repeat (ncyc) step();
    reset = 1'b0;
    foreach (mbuf[i]) mbuf[i] = 0;
    mwr = 0;
    while (!in_ready && n < 1000) begin
      if (out_valid || busy || out_sat || data_out != 0) bad++;
      n++;
      step();
    end
    check("clear_len", n, N);
    check("clear_quiet", bad, 0);
  endtask

  // mode 0: k+1, 1: full random, 2: all 0x7FFF, 3: small random with c[0]=7
  task automatic load_coef(input int mode);
    int v;
    for (int k = 0; k < N; k++) begin
      case (mode)
        0:       v = k + 1;
        1:       v = int'($urandom_range(0, 65535)) - 32768;
        2:       v = 32767;
        default: v = (k == 0) ? 7 : int'($urandom_range(0, 200)) - 100;
      endcase
      coeff_we    = 1'b1;
      coeff_addr  = AW'(k);
      coeff_wdata = 16'(v);
      step();
      mcoef[k] = v;
    end
    coeff_we = 1'b0;
  endtask

  task automatic write_coef(input int addr, input int val, input bit honored);
    coeff_we    = 1'b1;
    coeff_addr  = AW'(addr);
    coeff_wdata = 16'(val);
    step();
    coeff_we = 1'b0;
    if (honored && addr < N) mcoef[addr] = val;
  endtask

  // inj 1: coefficient write mid-RUN, inj 2: reset mid-RUN (no output expected).
  task automatic send(input int x, input int gap, input int stall, input int inj,
                      input bit tim);
    int n, busy_n, bad, t_acc;
    logic signed [63:0] exp_d;
    logic               exp_s;
    logic signed [31:0] held;
    repeat (gap) step();
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 2000) begin
      n++;
      step();
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    t_acc    = cyc;
    data_in  = 16'(x);
    in_valid = 1'b1;
    mbuf[mwr] = x;
    model_out(exp_d, exp_s);
    step();
    in_valid = 1'b0;
    n = 1;
    busy_n = 0;
    bad = 0;
    while (!out_valid && n < 1000) begin
      if (busy) busy_n++;
      if (in_ready) bad++;
      if (inj == 2 && n == 100) begin
        do_reset(1);
        return;
      end
      if (inj == 1 && n == 100) begin
        coeff_we    = 1'b1;
        coeff_addr  = '0;
        coeff_wdata = 16'sd5;
      end else begin
        coeff_we = 1'b0;
      end
      step();
      n++;
    end
    coeff_we = 1'b0;
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    check("in_ready_while_busy", bad, 0);
    if (tim) begin
      check("latency", cyc - t_acc, 323);
      check("busy_cycles", busy_n, N + 1);
      if (prev_acc >= 0) check("period", t_acc - prev_acc, 324);
      prev_acc = t_acc;
    end
    check("data_out", data_out, exp_d);
    check("out_sat", out_sat, exp_s);
    last_d = data_out;
    last_s = out_sat;
    if (stall > 0) begin
      held = data_out;
      bad  = 0;
      for (int i = 0; i < stall; i++) begin
        step();
        if (data_out != held || !out_valid || in_ready) bad++;
      end
      check("backpressure_hold", bad, 0);
      out_ready = 1'b1;
    end
    step();
    check("handshake_ovalid", out_valid, 0);
    check("next_in_ready", in_ready, 1);
    mwr = (mwr + 1) % N;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    data_in     = '0;
    out_ready   = 1'b1;
    coeff_we    = 1'b0;
    coeff_addr  = '0;
    coeff_wdata = '0;
    prev_acc    = -1;
    mwr         = 0;
    do_reset(3);

    // Impulse through ramp coefficients, timing and backpressure.
    load_coef(0);
    send(1, 0, 0, 0, 1);
    send(0, 0, 0, 0, 1);
    send(0, 0, 0, 0, 1);
    send(0, 0, 10, 0, 0);
    send(0, 0, 0, 0, 0);

    load_coef(1);
    repeat (20) send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)), 0, 0);

    // Saturation in both directions.
    load_coef(2);
    repeat (4) send(32767, 0, 0, 0, 0);
    check("sat_pos_data", last_d, 64'sd2147483647);
    check("sat_pos_flag", last_s, 1);
    repeat (10) send(-32768, 0, 0, 0, 0);
    check("sat_neg_data", last_d, -64'sd2147483648);
    check("sat_neg_flag", last_s, 1);

    // Reset mid-RUN, then impulse must see a clean buffer.
    send(12345, 0, 0, 2, 0);
    load_coef(3);
    send(1000, 0, 0, 0, 0);
    check("impulse_after_reset", last_d, 64'sd7000);
    send(int'($urandom_range(0, 200)) - 100, 0, 0, 0, 0);

    // Coefficient writes: dropped while busy or out of range, honoured in IDLE.
    send(50, 0, 0, 1, 0);
    send(40, 0, 0, 0, 0);
    write_coef(N, 5, 1'b0);
    send(30, 0, 0, 0, 0);
    write_coef(0, 5, 1'b1);
    send(20, 0, 0, 0, 0);

    do_reset(3);
    write_coef(0, 3, 1'b1);
    send(1, 0, 0, 0, 0);
    check("single_tap_data", last_d, 64'sd3);
    check("single_tap_sat", last_s, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
